sensor_porta_encoder: RTL

SENSOR_PORTA_ENCODER -- requirements
Module: sensor_porta_encoder

---
 rtl/porta_pkg.sv | 43 ++++
 rtl/debounce_bit.sv | 55 +++++
 rtl/sensor_porta_encoder.sv | 107 ++++++++++
 3 files changed

// File: rtl/porta_pkg.sv
// porta_pkg: shared definitions for the door sensor encoder.
//   CODE_W       width of the entrada code word
//   porta_state_t  encoder FSM states
//   SEG_OFF      active-low seven-segment image with every segment dark
//   hex_to_seg() active-low seven-segment image (gfedcba) of a hex digit
package porta_pkg;

    localparam int CODE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } porta_state_t;

    localparam logic [6:0] SEG_OFF = 7'b1111111;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
        logic [6:0] seg_hi;
        seg_hi = 7'h00;
        case (v)
            4'h0: seg_hi = 7'h3F;
            4'h1: seg_hi = 7'h06;
            4'h2: seg_hi = 7'h5B;
            4'h3: seg_hi = 7'h4F;
            4'h4: seg_hi = 7'h66;
            4'h5: seg_hi = 7'h6D;
            4'h6: seg_hi = 7'h7D;
            4'h7: seg_hi = 7'h07;
            4'h8: seg_hi = 7'h7F;
            4'h9: seg_hi = 7'h6F;
            4'hA: seg_hi = 7'h77;
            4'hB: seg_hi = 7'h7C;
            4'hC: seg_hi = 7'h39;
            4'hD: seg_hi = 7'h5E;
            4'hE: seg_hi = 7'h79;
            default: seg_hi = 7'h71;
        endcase
        // table is written active-high; the display pins are active-low
        return ~seg_hi;
    endfunction

endpackage

// File: rtl/debounce_bit.sv
// debounce_bit: two-flop synchroniser followed by a per-bit debouncer.
//   clock    single clock, rising edge
//   reset_n  asynchronous active-low reset
//   raw      asynchronous sensor input
//   stable   debounced level, updates once the synchronised bit has been
//            seen at the same value for DEBOUNCE_CYCLES consecutive samples
module debounce_bit #(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic clock,
    input  logic reset_n,
    input  logic raw,
    output logic stable
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

    logic             sync1;
    logic             sync2;
    logic             cand;
    logic [CNT_W-1:0] cnt;
    logic             mismatch;
    logic [8:0]       held;

    // cnt holds the number of matching samples after the one that reloaded
    // it, so the sample count including the current one is 1 on a reload and
    // cnt+2 otherwise. Deciding on the current sample keeps the bit latency
    // at 2 sync cycles plus exactly DEBOUNCE_CYCLES.
    assign mismatch = (sync2 != cand);
    assign held     = mismatch ? 9'd1 : (9'(cnt) + 9'd2);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            cand   <= 1'b0;
            cnt    <= '0;
            stable <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            if (mismatch) begin
                cand <= sync2;
                cnt  <= '0;
            end else if (cnt != CNT_MAX) begin
                cnt <= cnt + CNT_W'(1);
            end
            if (held >= 9'(DEBOUNCE_CYCLES)) begin
                stable <= sync2;
            end
        end
    end

endmodule

// File: rtl/sensor_porta_encoder.sv
// sensor_porta_encoder: debounces four door sensors and hands each new code
// to the door controller with a valid/ack handshake.
//   clock          single clock, rising edge
//   reset_n        asynchronous active-low reset
//   sensor_raw     raw asynchronous sensors, [3:0] matches the entrada word
//   entrada        debounced code offered to the door controller
//   entrada_valid  high while entrada is unacknowledged
//   entrada_ack    controller accepts entrada when high with entrada_valid
//   busy           high whenever the FSM is not idle
//   display        active-low seven-segment image of entrada
// Build option SENSOR_PORTA_DISPLAY_EN: registered hex decode of entrada on
// display; when undefined display is tied dark.
//
// state | meaning
// IDLE  | waiting for the stable word to differ from the last sent code
// SEND  | entrada frozen and valid, waiting for ack
// GAP   | one-cycle spacer after ack before the next compare
module sensor_porta_encoder
    import porta_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [CODE_W-1:0] sensor_raw,
    output logic [CODE_W-1:0] entrada,
    output logic              entrada_valid,
    input  logic              entrada_ack,
    output logic              busy,
    output logic [6:0]        display
);

    logic [CODE_W-1:0] stable_word;
    logic [CODE_W-1:0] last_sent;
    porta_state_t      state;
    porta_state_t      state_next;
    logic              load_entrada;
    logic              load_last;

    for (genvar i = 0; i < CODE_W; i++) begin : g_bit
        debounce_bit #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clock  (clock),
            .reset_n(reset_n),
            .raw    (sensor_raw[i]),
            .stable (stable_word[i])
        );
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // entrada_valid is only high in SEND, so ack outside SEND is ignored
    always_comb begin
        state_next   = state;
        load_entrada = 1'b0;
        load_last    = 1'b0;
        case (state)
            IDLE: begin
                if (stable_word != last_sent) begin
                    state_next   = SEND;
                    load_entrada = 1'b1;
                end
            end
            SEND: begin
                if (entrada_ack) begin
                    state_next = GAP;
                    load_last  = 1'b1;
                end
            end
            GAP:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            entrada   <= '0;
            last_sent <= '0;
        end else begin
            if (load_entrada) entrada   <= stable_word;
            if (load_last)    last_sent <= entrada;
        end
    end

    assign entrada_valid = (state == SEND);
    assign busy          = (state != IDLE);

`ifdef SENSOR_PORTA_DISPLAY_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            display <= SEG_OFF;
        end else begin
            display <= hex_to_seg(entrada);
        end
    end
`else
    assign display = SEG_OFF;
`endif

endmodule
